// File: rtl/div16x8_seq.sv
// div16x8_seq: sequential 16-by-8 unsigned restoring divider.
// One quotient bit per clock, start/done handshake, divide-by-zero
// answered in a single cycle with Q=16'hFFFF, R=N[7:0], dz=1.
module div16x8_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] N,
   input  logic [7:0]  D,
   output logic        busy,
   output logic        done,
   output logic [15:0] Q,
   output logic [7:0]  R,
   output logic        dz
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      state;
   state_t      nstate;
   logic [3:0]  cnt;
   logic [7:0]  rem;
   logic [15:0] dvd;
   logic [7:0]  dvs;
   logic [8:0]  rem_sh;
   logic [7:0]  rem_nx;
   logic        qbit;

   // One restoring step: shift the next dividend bit into the working
   // remainder (9 bits so the compare cannot overflow), subtract if it fits.
   // The stored remainder is always below the divisor, so 8 bits hold it.
   always_comb begin
      rem_sh = {rem, dvd[15]};
      qbit   = (rem_sh >= {1'b0, dvs});
      rem_nx = rem_sh[7:0];
      if (qbit) begin
         rem_nx = 8'(rem_sh - {1'b0, dvs});
      end
   end

   // State register; reset abandons any division in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= nstate;
      end
   end

   // Next state: IDLE and DONE both accept a new start; a zero divisor
   // skips RUN entirely and answers on the very next edge.
   always_comb begin
      nstate = state;
      case (state)
         S_RUN: begin
            if (cnt == 4'd15) begin
               nstate = S_DONE;
            end
         end
         default: begin
            if (start) begin
               nstate = (D == 8'd0) ? S_DONE : S_RUN;
            end else begin
               nstate = S_IDLE;
            end
         end
      endcase
   end

   // Datapath: capture operands on accept, iterate in RUN, and publish
   // results only on the final iteration so Q/R/dz hold between operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 4'd0;
         rem <= 8'd0;
         dvd <= 16'd0;
         dvs <= 8'd0;
         Q   <= 16'd0;
         R   <= 8'd0;
         dz  <= 1'b0;
      end else if (state == S_RUN) begin
         rem <= rem_nx;
         dvd <= {dvd[14:0], qbit};
         cnt <= cnt + 4'd1;
         if (cnt == 4'd15) begin
            Q  <= {dvd[14:0], qbit};
            R  <= rem_nx;
            dz <= 1'b0;
         end
      end else if (start) begin
         if (D == 8'd0) begin
            Q  <= 16'hFFFF;
            R  <= N[7:0];
            dz <= 1'b1;
         end else begin
            dvd <= N;
            dvs <= D;
            rem <= 8'd0;
            cnt <= 4'd0;
         end
      end
   end

   // Handshake flags decode straight from the registered state.
   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule
